// File: rtl/dual_regfile.sv
// Dual-write MIPS-style register file: r1..r31 plus HI/LO, fed by two writeback slots.
// Four combinational read ports; slot 2 (younger) wins every same-edge conflict.
module dual_regfile #(
  parameter bit BYPASS = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [207:0] wb_to_rf_bus,
  input  logic [4:0]   raddr_a1,
  input  logic [4:0]   raddr_b1,
  input  logic [4:0]   raddr_a2,
  input  logic [4:0]   raddr_b2,
  output logic [31:0]  rdata_a1,
  output logic [31:0]  rdata_b1,
  output logic [31:0]  rdata_a2,
  output logic [31:0]  rdata_b2,
  output logic [31:0]  hi_o,
  output logic [31:0]  lo_o
);

  logic [31:0] rf_wdata1, rf_wdata2;
  logic [4:0]  rf_waddr1, rf_waddr2;
  logic        rf_we1, rf_we2;
  logic [31:0] hi_wdata1, lo_wdata1, hi_wdata2, lo_wdata2;
  logic        hi_we1, lo_we1, hi_we2, lo_we2;

  logic [31:0] regs [32];
  logic [31:0] hi_reg, lo_reg;

  // Each slot occupies 104 bits: {hi_we, lo_we, hi_wdata, lo_wdata, rf_we, rf_waddr, rf_wdata}
  assign rf_wdata1 = wb_to_rf_bus[31:0];
  assign rf_waddr1 = wb_to_rf_bus[36:32];
  assign rf_we1    = wb_to_rf_bus[37];
  assign lo_wdata1 = wb_to_rf_bus[69:38];
  assign hi_wdata1 = wb_to_rf_bus[101:70];
  assign lo_we1    = wb_to_rf_bus[102];
  assign hi_we1    = wb_to_rf_bus[103];

  assign rf_wdata2 = wb_to_rf_bus[135:104];
  assign rf_waddr2 = wb_to_rf_bus[140:136];
  assign rf_we2    = wb_to_rf_bus[141];
  assign lo_wdata2 = wb_to_rf_bus[173:142];
  assign hi_wdata2 = wb_to_rf_bus[205:174];
  assign lo_we2    = wb_to_rf_bus[206];
  assign hi_we2    = wb_to_rf_bus[207];

  function automatic logic [31:0] read_port(
    input logic [4:0]  addr,
    input logic [31:0] stored,
    input logic        we1,
    input logic [4:0]  a1,
    input logic [31:0] d1,
    input logic        we2,
    input logic [4:0]  a2,
    input logic [31:0] d2
  );
    logic [31:0] val;
    if (addr == 5'd0) begin
      val = 32'd0;
    end else if (BYPASS && we2 && (a2 == addr)) begin
      val = d2;
    end else if (BYPASS && we1 && (a1 == addr)) begin
      val = d1;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Later slot-2 assignments override slot 1 on the same edge; r0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
      hi_reg <= 32'd0;
      lo_reg <= 32'd0;
    end else begin
      if (rf_we1 && (rf_waddr1 != 5'd0)) begin
        regs[rf_waddr1] <= rf_wdata1;
      end
      if (rf_we2 && (rf_waddr2 != 5'd0)) begin
        regs[rf_waddr2] <= rf_wdata2;
      end
      if (hi_we2) begin
        hi_reg <= hi_wdata2;
      end else if (hi_we1) begin
        hi_reg <= hi_wdata1;
      end
      if (lo_we2) begin
        lo_reg <= lo_wdata2;
      end else if (lo_we1) begin
        lo_reg <= lo_wdata1;
      end
    end
  end

  // GPR read ports with optional same-cycle forwarding
  always_comb begin
    rdata_a1 = read_port(raddr_a1, regs[raddr_a1], rf_we1, rf_waddr1, rf_wdata1,
                         rf_we2, rf_waddr2, rf_wdata2);
    rdata_b1 = read_port(raddr_b1, regs[raddr_b1], rf_we1, rf_waddr1, rf_wdata1,
                         rf_we2, rf_waddr2, rf_wdata2);
    rdata_a2 = read_port(raddr_a2, regs[raddr_a2], rf_we1, rf_waddr1, rf_wdata1,
                         rf_we2, rf_waddr2, rf_wdata2);
    rdata_b2 = read_port(raddr_b2, regs[raddr_b2], rf_we1, rf_waddr1, rf_wdata1,
                         rf_we2, rf_waddr2, rf_wdata2);
  end

  // HI/LO outputs, forwarded independently at the same slot priority as the write
  always_comb begin
    hi_o = hi_reg;
    lo_o = lo_reg;
    if (BYPASS && hi_we2) begin
      hi_o = hi_wdata2;
    end else if (BYPASS && hi_we1) begin
      hi_o = hi_wdata1;
    end else begin
      hi_o = hi_reg;
    end
    if (BYPASS && lo_we2) begin
      lo_o = lo_wdata2;
    end else if (BYPASS && lo_we1) begin
      lo_o = lo_wdata1;
    end else begin
      lo_o = lo_reg;
    end
  end

endmodule

// File: tb/tb_dual_regfile.sv
// Bench for dual_regfile: a BYPASS=1 and a BYPASS=0 instance share one bus, checked
// against an array model with directed corner cases and randomized traffic.
`timescale 1ns/1ps
module tb_dual_regfile;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [207:0] bus;
  logic [4:0]   ra [4];
  logic [31:0]  rd1 [4];
  logic [31:0]  rd0 [4];
  logic [31:0]  hi1, lo1, hi0, lo0;

  logic        we  [1:2];
  logic [4:0]  wa  [1:2];
  logic [31:0] wd  [1:2];
  logic        hwe [1:2];
  logic        lwe [1:2];
  logic [31:0] hd  [1:2];
  logic [31:0] ld  [1:2];

  logic [31:0] mem [32];
  logic [31:0] m_hi, m_lo;

  int n_checks = 0;
  int n_pass = 0;

  dual_regfile #(.BYPASS(1'b1)) dut_byp (
    .clk(clk), .rst(rst), .wb_to_rf_bus(bus),
    .raddr_a1(ra[0]), .raddr_b1(ra[1]), .raddr_a2(ra[2]), .raddr_b2(ra[3]),
    .rdata_a1(rd1[0]), .rdata_b1(rd1[1]), .rdata_a2(rd1[2]), .rdata_b2(rd1[3]),
    .hi_o(hi1), .lo_o(lo1)
  );

  dual_regfile #(.BYPASS(1'b0)) dut_nobyp (
    .clk(clk), .rst(rst), .wb_to_rf_bus(bus),
    .raddr_a1(ra[0]), .raddr_b1(ra[1]), .raddr_a2(ra[2]), .raddr_b2(ra[3]),
    .rdata_a1(rd0[0]), .rdata_b1(rd0[1]), .rdata_a2(rd0[2]), .rdata_b2(rd0[3]),
    .hi_o(hi0), .lo_o(lo0)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    bus = {hwe[2], lwe[2], hd[2], ld[2], we[2], wa[2], wd[2],
           hwe[1], lwe[1], hd[1], ld[1], we[1], wa[1], wd[1]};
  endtask

  task automatic clear_bus();
    for (int s = 1; s <= 2; s++) begin
      we[s] = 1'b0; wa[s] = 5'd0; wd[s] = 32'd0;
      hwe[s] = 1'b0; lwe[s] = 1'b0; hd[s] = 32'd0; ld[s] = 32'd0;
    end
    drive();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    m_hi = 32'd0;
    m_lo = 32'd0;
  endtask

  // A read sees the youngest matching write on the bus (if forwarding), else the stored value.
  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    logic [31:0] v;
    if (a == 5'd0) return 32'd0;
    v = mem[a];
    if (byp) for (int s = 1; s <= 2; s++) if (we[s] && wa[s] == a) v = wd[s];
    return v;
  endfunction

  function automatic logic [31:0] exp_hl(input bit is_hi, input bit byp);
    logic [31:0] v;
    v = is_hi ? m_hi : m_lo;
    if (byp) begin
      for (int s = 1; s <= 2; s++) begin
        if (is_hi && hwe[s]) v = hd[s];
        if (!is_hi && lwe[s]) v = ld[s];
      end
    end
    return v;
  endfunction

  task automatic model_commit();
    for (int s = 1; s <= 2; s++) begin
      if (we[s] && wa[s] != 5'd0) mem[wa[s]] = wd[s];
      if (hwe[s]) m_hi = hd[s];
      if (lwe[s]) m_lo = ld[s];
    end
  endtask

  task automatic check_all();
    for (int p = 0; p < 4; p++) begin
      check_eq($sformatf("byp_rd%0d_a%0d", p, ra[p]), rd1[p], exp_rd(ra[p], 1'b1));
      check_eq($sformatf("nob_rd%0d_a%0d", p, ra[p]), rd0[p], exp_rd(ra[p], 1'b0));
    end
    check_eq("byp_hi", hi1, exp_hl(1'b1, 1'b1));
    check_eq("byp_lo", lo1, exp_hl(1'b0, 1'b1));
    check_eq("nob_hi", hi0, exp_hl(1'b1, 1'b0));
    check_eq("nob_lo", lo0, exp_hl(1'b0, 1'b0));
  endtask

  // Starts just after a falling edge: check, take the rising edge, return at the next falling edge.
  task automatic tick();
    #2;
    check_all();
    @(posedge clk);
    if (!rst) model_commit();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    clear_bus();
    for (int p = 0; p < 4; p++) ra[p] = 5'd0;
    @(negedge clk);

    // Reset state, and forwarding still visible while reset holds storage at zero
    ra[0] = 5'd5; ra[1] = 5'd6; ra[2] = 5'd7; ra[3] = 5'd31;
    #1;
    check_eq("rst_r5", rd0[0], 32'd0);
    check_eq("rst_hi", hi0, 32'd0);
    we[1] = 1'b1; wa[1] = 5'd5; wd[1] = 32'h0000_0055; drive();
    #1;
    check_eq("rst_byp_r5", rd1[0], 32'h0000_0055);
    check_eq("rst_nob_r5", rd0[0], 32'd0);
    @(posedge clk);
    @(negedge clk);
    clear_bus();
    rst = 1'b0;
    #1;
    check_eq("rst_blocked_r5", rd0[0], 32'd0);
    @(negedge clk);

    // Dual write to r5/r6
    we[1] = 1'b1; wa[1] = 5'd5; wd[1] = 32'h1111_1111;
    we[2] = 1'b1; wa[2] = 5'd6; wd[2] = 32'h2222_2222; drive();
    tick();
    clear_bus();
    #1;
    check_eq("dual_r5", rd0[0], 32'h1111_1111);
    check_eq("dual_r6", rd0[1], 32'h2222_2222);
    tick();

    // Same-address conflict on r7
    ra[0] = 5'd7;
    we[1] = 1'b1; wa[1] = 5'd7; wd[1] = 32'hAAAA_0000;
    we[2] = 1'b1; wa[2] = 5'd7; wd[2] = 32'hBBBB_0000; drive();
    #1;
    check_eq("conf_byp_r7", rd1[0], 32'hBBBB_0000);
    check_eq("conf_nob_r7", rd0[0], 32'd0);
    tick();
    clear_bus();
    #1;
    check_eq("conf_r7", rd0[0], 32'hBBBB_0000);
    tick();

    // Writes to r0 are dropped and never forwarded
    ra[0] = 5'd0;
    we[1] = 1'b1; wa[1] = 5'd0; wd[1] = 32'hFFFF_FFFF;
    we[2] = 1'b1; wa[2] = 5'd0; wd[2] = 32'hFFFF_FFFF; drive();
    #1;
    check_eq("r0_byp", rd1[0], 32'd0);
    tick();
    clear_bus();
    #1;
    check_eq("r0_after", rd0[0], 32'd0);
    tick();

    // Disabled write carrying a live address
    ra[0] = 5'd9;
    we[1] = 1'b0; wa[1] = 5'd9; wd[1] = 32'hDEAD_BEEF; drive();
    #1;
    check_eq("dis_byp_r9", rd1[0], 32'd0);
    tick();
    clear_bus();
    #1;
    check_eq("dis_r9", rd0[0], 32'd0);
    tick();

    // HI/LO partial overlap
    hwe[1] = 1'b1; lwe[1] = 1'b1; hd[1] = 32'h1; ld[1] = 32'h2;
    hwe[2] = 1'b0; lwe[2] = 1'b1; hd[2] = $urandom; ld[2] = 32'h3; drive();
    #1;
    check_eq("hl_byp_hi", hi1, 32'h1);
    check_eq("hl_byp_lo", lo1, 32'h3);
    tick();
    clear_bus();
    #1;
    check_eq("hl_hi", hi0, 32'h1);
    check_eq("hl_lo", lo0, 32'h3);
    tick();

    // Reset landing on a pending write loses it; the next edge with rst low commits it
    ra[0] = 5'd10;
    we[1] = 1'b1; wa[1] = 5'd10; wd[1] = 32'hCAFE_F00D; drive();
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
    #1;
    check_eq("midrst_lost", rd0[0], 32'd0);
    tick();
    clear_bus();
    #1;
    check_eq("midrst_first", rd0[0], 32'hCAFE_F00D);
    tick();

    // Randomized traffic with addresses biased toward a small set to force collisions
    for (int n = 0; n < 400; n++) begin
      for (int s = 1; s <= 2; s++) begin
        we[s]  = 1'($urandom_range(0, 1));
        wa[s]  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        wd[s]  = $urandom;
        hwe[s] = 1'($urandom_range(0, 1));
        lwe[s] = 1'($urandom_range(0, 1));
        hd[s]  = $urandom;
        ld[s]  = $urandom;
      end
      for (int p = 0; p < 4; p++) begin
        ra[p] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      end
      drive();
      tick();
    end

    // Fill r1..r31 with their index, then assert reset between edges
    for (int i = 1; i < 32; i += 2) begin
      clear_bus();
      we[1] = 1'b1; wa[1] = 5'(i); wd[1] = 32'(i);
      if (i + 1 < 32) begin
        we[2] = 1'b1; wa[2] = 5'(i + 1); wd[2] = 32'(i + 1);
      end
      hwe[1] = 1'b1; lwe[1] = 1'b1; hd[1] = 32'h0000_00AA; ld[1] = 32'h0000_00BB;
      drive();
      tick();
    end
    clear_bus();
    ra[0] = 5'd1; ra[1] = 5'd17; ra[2] = 5'd30; ra[3] = 5'd31;
    #1;
    check_eq("fill_r1", rd0[0], 32'd1);
    check_eq("fill_r17", rd0[1], 32'd17);
    check_eq("fill_r30", rd0[2], 32'd30);
    check_eq("fill_r31", rd0[3], 32'd31);
    rst = 1'b1;
    model_reset();
    for (int g = 0; g < 8; g++) begin
      for (int p = 0; p < 4; p++) ra[p] = 5'(g * 4 + p);
      #0.2;
      for (int p = 0; p < 4; p++) check_eq($sformatf("arst_r%0d", g * 4 + p), rd0[p], 32'd0);
    end
    check_eq("arst_hi", hi0, 32'd0);
    check_eq("arst_lo", lo0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dual_regfile.md
DUAL_REGFILE -- requirements
Module: dual_regfile

Interface
REQ-001 SHALL have parameter: BYPASS, 1, 1 = same-cycle write-to-read forwarding on all read ports; 0 = reads return stored state only.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port wb_to_rf_bus, input, `WB_TO_RF_WD (208), write bus from writeback; packed MSB to LSB as {hilo_bus_i2, rf_we_i2, rf_waddr_i2[4:0], rf_wdata_i2[31:0], hilo_bus_i1, rf_we_i1, rf_waddr_i1[4:0], rf_wdata_i1[31:0]}.
REQ-005 SHALL decode each hilo_bus_iN (`HILO_WD = 66) as {hi_we, lo_we, hi_wdata[31:0], lo_wdata[31:0]}.
REQ-006 SHALL have ports raddr_a1, raddr_b1, raddr_a2, raddr_b2, input, 5 each: rs/rt read addresses for issue slots 1 and 2.
REQ-007 SHALL have ports rdata_a1, rdata_b1, rdata_a2, rdata_b2, output, 32 each: read data for the matching address.
REQ-008 SHALL have ports hi_o and lo_o, output, 32 each: current HI/LO values.

Function
REQ-009 SHALL hold 31 writable 32-bit registers r1..r31; r0 reads 0 always, and writes to r0 are discarded.
REQ-010 SHALL write rf_wdata_iN to rf_waddr_iN on the rising clk edge when rf_we_iN=1 and rf_waddr_iN != 0, giving a latency of one edge.
REQ-011 SHALL, on a same-edge write to one address by both slots, store the slot-2 value, since slot 2 is the younger instruction.
REQ-012 SHALL write HI from hi_wdata_iN when hi_we_iN=1, and LO from lo_wdata_iN when lo_we_iN=1, on the rising edge; HI and LO are independent.
REQ-013 SHALL, on a same-edge HI (or LO) write by both slots, take the slot-2 value; on a partial overlap (e.g. i1 writes HI and LO, i2 writes LO only), take HI from i1 and LO from i2.
REQ-014 SHALL provide combinational read ports with no clock latency from address to data.
REQ-015 SHALL, when BYPASS=1, drive a read port with the same-cycle write data whose enable is set and whose address matches (nonzero); priority is i2 > i1 > stored value.
REQ-016 SHALL, when BYPASS=1, drive hi_o/lo_o with the same-cycle HI/LO write data at the REQ-013 priority, otherwise the stored value.
REQ-017 SHALL, when BYPASS=0, drive all read outputs from stored state only, so that new data appears after the edge.
REQ-018 SHALL return 0 when reading address 0, regardless of any bypass candidate addressed to 0.
REQ-019 SHALL ignore an all-zero bus (a bubble) as a no-op, with no state change.
REQ-020 SHALL ignore rf_waddr_iN/rf_wdata_iN when rf_we_iN=0, even if the bubble carries a nonzero address.

Reset
REQ-021 SHALL, on rst=1, clear all registers, HI and LO to 0 immediately, without waiting for clk.
REQ-022 SHALL, while rst=1, block all writes; with BYPASS=1, read outputs still reflect bus bypass terms while stored state stays 0.
REQ-023 SHALL, on rst asserted mid-stream, lose any write pending on that edge; the first write after deassertion takes effect on the first rising edge with rst=0.

Verification
REQ-024 SHALL cover dual write: i1 writes r5=0x11111111 and i2 writes r6=0x22222222 on one edge; next cycle reads of r5/r6 -> 0x11111111/0x22222222.
REQ-025 SHALL cover a same-address conflict: i1 and i2 both write r7 with 0xAAAA0000/0xBBBB0000; after the edge r7 -> 0xBBBB0000; with BYPASS=1, a same-cycle read of r7 -> 0xBBBB0000.
REQ-026 SHALL cover r0: both slots write r0=0xFFFFFFFF; the read of r0 in the same cycle and after the edge -> 0.
REQ-027 SHALL cover HILO partial overlap: i1 {hi_we=1, lo_we=1, 0x1, 0x2}, i2 {hi_we=0, lo_we=1, x, 0x3}; after the edge hi_o=0x1, lo_o=0x3.
REQ-028 SHALL cover asynchronous reset: fill r1..r31 with their index, then assert rst between edges; all reads and hi_o/lo_o -> 0 before the next edge (BYPASS=0 run).
REQ-029 SHALL cover a disabled write: rf_we_i1=0 with waddr=9 and wdata=0xDEADBEEF; r9 stays unchanged, and the bypass does not fire.
